iter_divider: RTL and testbench

- Iterative radix-2 restoring divider for MIPS DIV/DIVU.
- Counterpart of the execute-stage shift-add multiplier, with the same start/sign/completed handshake toward the execute stage.
- Produces quotient on lo and remainder on hi, matching HI/LO semantics.
- Sits beside the multiplier in the execute stage. The execute stage holds the pipeline while busy is high.

---
 rtl/iter_divider_pkg.sv | 13 +
 rtl/iter_divider_div_step.sv | 24 ++
 rtl/iter_divider.sv | 155 +++++++++++++++
 tb/tb_iter_divider.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iter_divider_pkg.sv
// Definitions shared by the execute-stage iterative units (this divider and the
// shift-add multiplier): the sequencing state encoding and the default data width.
package iter_divider_pkg;

   localparam int DEF_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_e;

endpackage

// File: rtl/iter_divider_div_step.sv
// One radix-2 restoring-division iteration: shift {rem, quo} left, trial-subtract
// the divisor magnitude, and keep the difference only when it is non-negative.
module iter_divider_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] dmag_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] trial;

   // The extra top bit of trial is the borrow: set means rem_sh < divisor.
   always_comb begin
      rem_sh = {rem_i, quo_i[WIDTH-1]};
      trial  = rem_sh - {1'b0, dmag_i};
      quo_o  = {quo_i[WIDTH-2:0], ~trial[WIDTH]};
      rem_o  = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
   end

endmodule

// File: rtl/iter_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU: quotient on lo, remainder on hi,
// one result bit per cycle, done pulses WIDTH+1 edges after start is accepted.
module iter_divider
   import iter_divider_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sgn,
   input  logic             cancel,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                 input logic             neg);
      return neg ? -v : v;
   endfunction

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dmag_q, dmag_d;
   logic [WIDTH-1:0] dvnd_q, dvnd_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic             dz_q, dz_d;
   logic             done_q, done_d;
   logic             dbz_q, dbz_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] rem_nx, quo_nx;
   logic             a_neg, b_neg;

   assign a_neg = sgn & dividend[WIDTH-1];
   assign b_neg = sgn & divisor[WIDTH-1];

   iter_divider_div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem_i  (rem_q),
      .quo_i  (quo_q),
      .dmag_i (dmag_q),
      .rem_o  (rem_nx),
      .quo_o  (quo_nx)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dmag_d  = dmag_q;
      dvnd_d  = dvnd_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      done_d  = 1'b0;
      dbz_d   = dbz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;

      unique case (state_q)
         IDLE: begin
            // The dividend magnitude is preloaded into the quotient register and
            // shifted out through the top bit as quotient bits shift in.
            if (start && !cancel) begin
               state_d = RUN;
               cnt_d   = '0;
               rem_d   = '0;
               quo_d   = cond_neg(dividend, a_neg);
               dmag_d  = cond_neg(divisor, b_neg);
               qneg_d  = a_neg ^ b_neg;
               rneg_d  = a_neg;
               dvnd_d  = dividend;
               dz_d    = (divisor == '0);
            end
         end
         RUN: begin
            if (cancel) begin
               state_d = IDLE;
            end else begin
               rem_d = rem_nx;
               quo_d = quo_nx;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_CNT) begin
                  state_d = FIX;
               end
            end
         end
         FIX: begin
            state_d = IDLE;
            if (!cancel) begin
               done_d = 1'b1;
               dbz_d  = dz_q;
               if (dz_q) begin
                  lo_d = '1;
                  hi_d = dvnd_q;
               end else begin
                  lo_d = cond_neg(quo_q, qneg_q);
                  hi_d = cond_neg(rem_q, rneg_q);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // Working operands are always reloaded on start, so they carry no reset.
   always_ff @(posedge clk) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dmag_q <= dmag_d;
      dvnd_q <= dvnd_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
   end

   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: expected results are queued when a division
// is started and popped when done pulses.
module tb_iter_divider;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic         sgn = 1'b0;
   logic         cancel = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy, done, div_by_zero;
   logic [W-1:0] hi, lo;

   typedef struct packed {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   iter_divider #(
      .WIDTH (W),
      .CNT_W (6)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .sgn         (sgn),
      .cancel      (cancel),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .hi          (hi),
      .lo          (lo),
      .div_by_zero (div_by_zero)
   );

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      exp_t e;
      e.dz = 1'b0;
      if (b == '0) begin
         e.q  = '1;
         e.r  = a;
         e.dz = 1'b1;
      end else if (s) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000;
            e.r = '0;
         end else begin
            e.q = W'($signed(a) / $signed(b));
            e.r = W'($signed(a) % $signed(b));
         end
      end else begin
         e.q = a / b;
         e.r = a % b;
      end
      return e;
   endfunction

   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("done_without_op", W'(done), '0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("lo", lo, e.q);
            check("hi", hi, e.r);
            check("div_by_zero", W'(div_by_zero), W'(e.dz));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      dividend = a;
      divisor  = b;
      sgn      = s;
      start    = 1'b1;
      sb_q.push_back(model(a, b, s));
      step();
      start    = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      sgn      = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_done(output int lat, output int busy_cnt);
      lat      = 0;
      busy_cnt = 0;
      while (done !== 1'b1 && lat < 100) begin
         if (busy === 1'b1) busy_cnt++;
         step();
         lat++;
      end
      if (done !== 1'b1) check("done_timeout", W'(done), W'(1));
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      int lat, bc;
      do_start(a, b, s);
      wait_done(lat, bc);
      check("latency", W'(lat), W'(33));
      check("busy_cycles", W'(bc), W'(33));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   lat, bc, seen;
      exp_t prev;

      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", W'(busy), '0);
      check("rst_done", W'(done), '0);
      check("rst_hi", hi, '0);
      check("rst_lo", lo, '0);
      check("rst_dbz", W'(div_by_zero), '0);
      @(negedge clk);
      rst = 1'b1;
      step();

      run_op(32'd100, 32'd7, 1'b0);
      check("q_100_7", lo, 32'd14);
      check("r_100_7", hi, 32'd2);
      run_op(32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
      run_op(32'h0000_0007, 32'hFFFF_FFFE, 1'b1);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      check("q_ovf", lo, 32'h8000_0000);
      check("r_ovf", hi, 32'h0000_0000);
      run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      run_op(32'h0000_1234, 32'h0000_0000, 1'b1);
      check("dz_flag", W'(div_by_zero), W'(1));
      run_op(32'h8000_0000, 32'h0000_0000, 1'b0);

      for (int i = 0; i < 8; i++) begin
         logic [W-1:0] a, b;
         a = $urandom;
         b = (i % 2 == 0) ? W'($urandom_range(1, 255)) : $urandom;
         run_op(a, b, 1'(i % 3 != 0));
      end

      // A second start mid-run must be ignored.
      do_start(32'd1000, 32'd10, 1'b0);
      repeat (5) step();
      dividend = 32'd7;
      divisor  = 32'd0;
      sgn      = 1'b1;
      start    = 1'b1;
      step();
      start    = 1'b0;
      wait_done(lat, bc);
      check("latency_ignored_start", W'(lat + 6), W'(33));

      // start accepted in the cycle done is high.
      run_op(32'd50, 32'd5, 1'b0);
      check("done_at_restart", W'(done), W'(1));
      run_op(32'd9, 32'd3, 1'b0);
      prev = model(32'd9, 32'd3, 1'b0);

      // cancel mid-run: no done, previous result kept.
      do_start(32'd12345, 32'd17, 1'b0);
      repeat (9) step();
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      void'(sb_q.pop_back());
      check("busy_after_cancel", W'(busy), '0);
      seen = 0;
      repeat (40) begin
         step();
         if (done === 1'b1) seen++;
      end
      check("no_done_after_cancel", W'(seen), '0);
      check("lo_kept", lo, prev.q);
      check("hi_kept", hi, prev.r);

      // cancel and start together in IDLE: cancel wins.
      cancel   = 1'b1;
      start    = 1'b1;
      dividend = 32'd77;
      divisor  = 32'd7;
      step();
      cancel = 1'b0;
      start  = 1'b0;
      check("cancel_beats_start", W'(busy), '0);

      // Asynchronous reset mid-operation, with non-zero outputs beforehand.
      run_op(32'hCAFE_0001, 32'h0000_0000, 1'b0);
      do_start(32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
      repeat (19) step();
      #2;
      rst = 1'b0;
      #1;
      check("arst_busy", W'(busy), '0);
      check("arst_done", W'(done), '0);
      check("arst_hi", hi, '0);
      check("arst_lo", lo, '0);
      check("arst_dbz", W'(div_by_zero), '0);
      sb_q.delete();
      @(negedge clk);
      rst = 1'b1;
      step();

      run_op(32'd100, 32'd7, 1'b0);
      check("q_after_rst", lo, 32'd14);
      check("r_after_rst", hi, 32'd2);
      step();
      check("sb_drained", W'(sb_q.size()), '0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
